// File: rtl/multichannel_event_classifier_if.sv
// Sample/class bundle for the multichannel event classifier.
// master: detector side + class consumer; slave: the classifier.
interface multichannel_event_classifier_if #(
  parameter int NUM_CH = 4
);
  logic                sample_valid;
  logic [NUM_CH-1:0]   detection;
  logic [NUM_CH-1:0]   ch_enable;
  logic [2*NUM_CH-1:0] class_out;
  logic [1:0]          global_class;
  logic                class_valid;
  logic                class_change;

  modport master (
    output sample_valid, detection, ch_enable,
    input  class_out, global_class,
    input  class_valid, class_change
  );

  modport slave (
    input  sample_valid, detection, ch_enable,
    output class_out, global_class,
    output class_valid, class_change
  );
endinterface

// File: rtl/multichannel_event_classifier.sv
// Per-channel excitability classifier (C/B/A) with decay, timeout, refractory.
// Ports: clk, reset (sync, active-high), bus (slave modport of the _if bundle).
module multichannel_event_classifier #(
  parameter int NUM_CH       = 4,
  parameter int EXC_W        = 16,
  parameter int CNT_W        = 16,
  parameter int EXC_STEP     = 100,
  parameter int EXC_SAT      = 1000,
  parameter int A_LEVEL      = 500,
  parameter int B_LEVEL      = 100,
  parameter int CONFIRM_A    = 5,
  parameter int DECAY_PERIOD = 1000,
  parameter int DECAY_STEP   = 100,
  parameter int TIMEOUT      = 10000,
  parameter int REFRACTORY   = 10000
) (
  input logic clk,
  input logic reset,
  multichannel_event_classifier_if.slave bus
);
  localparam int CF_W = $clog2(CONFIRM_A + 1);

  localparam logic [1:0] CL_C = 2'd0;
  localparam logic [1:0] CL_B = 2'd1;
  localparam logic [1:0] CL_A = 2'd2;

  localparam logic [EXC_W:0]   STEP_X = (EXC_W+1)'(EXC_STEP);
  localparam logic [EXC_W:0]   SAT_X  = (EXC_W+1)'(EXC_SAT);
  localparam logic [EXC_W:0]   DEC_X  = (EXC_W+1)'(DECAY_STEP);
  localparam logic [EXC_W-1:0] A_E    = EXC_W'(A_LEVEL);
  localparam logic [EXC_W-1:0] B_E    = EXC_W'(B_LEVEL);
  localparam logic [CNT_W-1:0] PER_C  = CNT_W'(DECAY_PERIOD);
  localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] REF_C  = CNT_W'(REFRACTORY);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CF_W-1:0]  CF_C   = CF_W'(CONFIRM_A);
  localparam logic [CF_W-1:0]  CF_ONE = CF_W'(1);

  logic [1:0]        cls [NUM_CH];
  logic [NUM_CH-1:0] chg;
  logic [1:0]        gmax;
  logic [1:0]        gc_q;
  logic              sv_d;
  logic              chg_d;
  logic              cv_q;
  logic              cc_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [EXC_W-1:0] exc, exc_n;
    logic [CNT_W-1:0] quiet, quiet_n;
    logic [CNT_W-1:0] since, since_n;
    logic [CNT_W-1:0] refr, refr_n;
    logic [CF_W-1:0]  conf, conf_n;
    logic [1:0]       cl, cl_n;
    logic [EXC_W:0]   sum;
    logic             det;
    logic             tmo;

    assign det = bus.detection[i];

    always_ff @(posedge clk) begin
      if (reset) begin
        exc   <= '0;
        quiet <= '0;
        since <= '0;
        refr  <= '0;
        conf  <= '0;
        cl    <= CL_C;
      end else begin
        exc   <= exc_n;
        quiet <= quiet_n;
        since <= since_n;
        refr  <= refr_n;
        conf  <= conf_n;
        cl    <= cl_n;
      end
    end

    always_comb begin
      exc_n   = exc;
      quiet_n = quiet;
      since_n = since;
      refr_n  = refr;
      conf_n  = conf;
      cl_n    = cl;
      sum     = {1'b0, exc} + STEP_X;
      tmo     = 1'b0;
      if (!bus.ch_enable[i]) begin
        exc_n   = '0;
        quiet_n = '0;
        since_n = '0;
        refr_n  = '0;
        conf_n  = '0;
        cl_n    = CL_C;
      end else if (bus.sample_valid) begin
        if (refr != '0) refr_n = refr - ONE_C;
        if (det) begin
          exc_n   = (sum > SAT_X) ? SAT_X[EXC_W-1:0]
                                  : sum[EXC_W-1:0];
          quiet_n = '0;
          since_n = '0;
        end else begin
          quiet_n = quiet + ONE_C;
          if (since != TO_C) since_n = since + ONE_C;
          if (quiet_n == PER_C) begin
            quiet_n = '0;
            exc_n   = ({1'b0, exc} > DEC_X)
                    ? exc - DEC_X[EXC_W-1:0] : '0;
          end
          tmo = (since_n == TO_C);
        end
        if (tmo) begin
          exc_n  = '0;
          conf_n = '0;
          cl_n   = CL_C;
          if (cl == CL_A) refr_n = REF_C;
        end else begin
          if (exc_n >= A_E)
            conf_n = (conf == CF_C) ? conf : conf + CF_ONE;
          else
            conf_n = '0;
          // C->B gate uses refr before this sample's decrement
          unique case (cl)
            CL_C: begin
              if (conf_n == CF_C) cl_n = CL_A;
              else if (exc_n >= B_E && refr == '0) cl_n = CL_B;
            end
            CL_B: begin
              if (conf_n == CF_C) cl_n = CL_A;
              else if (exc_n < B_E) cl_n = CL_C;
            end
            CL_A: begin
              if (exc_n < B_E) begin
                cl_n   = CL_C;
                refr_n = REF_C;
              end else if (exc_n < A_E) begin
                cl_n   = CL_B;
                refr_n = REF_C;
              end
            end
            default: cl_n = CL_C;
          endcase
        end
      end
    end

    assign cls[i] = cl;
    assign chg[i] = bus.sample_valid & (cl_n != cl);
    assign bus.class_out[2*i +: 2] = cl;
  end

  always_comb begin
    gmax = CL_C;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.ch_enable[i] && cls[i] > gmax) gmax = cls[i];
  end

  // second stage: global class lines up with the delayed strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      sv_d  <= 1'b0;
      chg_d <= 1'b0;
      gc_q  <= CL_C;
      cv_q  <= 1'b0;
      cc_q  <= 1'b0;
    end else begin
      sv_d  <= bus.sample_valid;
      chg_d <= |chg;
      gc_q  <= gmax;
      cv_q  <= sv_d;
      cc_q  <= chg_d;
    end
  end

  assign bus.global_class = gc_q;
  assign bus.class_valid  = cv_q;
  assign bus.class_change = cc_q;
endmodule

// File: doc/multichannel_event_classifier.md
# multichannel_event_classifier

Parametrised, multi-channel successor to the single-channel excitability classifier. It takes one detection bit per recording channel, once per sample strobe. For each channel it tracks an excitability score and classifies activity as C (background), B (interictal) or A (ictal), with linear decay, A-confirmation, post-A refractory suppression and quiet-timeout. It sits downstream of the per-channel spike detectors. It feeds per-channel and global (worst-channel) class codes to the stimulation/logging logic.

## Interface
- NUM_CH, 4: number of channels, ≥1
- EXC_W, 16: excitability register width
- CNT_W, 16: width of per-channel sample counters
- EXC_STEP, 100: excitability added per detection
- EXC_SAT, 1000: excitability ceiling; must be < 2^EXC_W
- A_LEVEL, 500: excitability threshold for class A
- B_LEVEL, 100: excitability threshold for class B
- CONFIRM_A, 5: consecutive samples ≥A_LEVEL needed to enter A; ≥1
- DECAY_PERIOD, 1000: consecutive quiet samples per decay step; ≥1
- DECAY_STEP, 100: excitability removed per decay step; 0 disables decay
- TIMEOUT, 10000: consecutive quiet samples forcing class C
- REFRACTORY, 10000: samples after leaving A during which C→B is blocked
- DECAY_PERIOD, TIMEOUT and REFRACTORY must each be < 2^CNT_W.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sample_valid  in  1  one-cycle strobe; detection is sampled only when high
- detection  in  NUM_CH  per-channel detection bit; bit i is channel i
- ch_enable  in  NUM_CH  per-channel enable; quasi-static
- class_out  out  2*NUM_CH  per-channel class; bits [2i+1:2i] belong to channel i
- global_class  out  2  maximum class over enabled channels
- class_valid  out  1  high one cycle when outputs reflect a new sample
- class_change  out  1  high with class_valid if any channel's class changed

## Operation
- Class codes: C=0, B=1, A=2. Code 3 is never produced.
- Per-channel state:
  - exc (EXC_W bits)
  - quiet (counts to DECAY_PERIOD)
  - since_det (saturates at TIMEOUT)
  - conf (saturates at CONFIRM_A)
  - refr (counts down from REFRACTORY)
  - class
- All state updates only on edges where sample_valid=1. Otherwise everything holds.
- Disabled channel (ch_enable[i]=0): all of its state is held at reset values, and it is excluded from global_class.
- Excitability, computed as exc_next and applied at the same edge:
  - If detection: exc_next=min(exc+EXC_STEP, EXC_SAT), with no wrap. quiet and since_det clear to 0.
  - If no detection: quiet+1 and since_det+1 (since_det saturating at TIMEOUT).
    - If quiet+1==DECAY_PERIOD: exc_next=max(exc−DECAY_STEP, 0) and quiet clears to 0.
    - Otherwise exc_next=exc.
- Timeout has highest priority. If since_det+1 reaches TIMEOUT on a quiet sample:
  - class→C, exc→0, conf→0.
  - If the previous class was A, refr loads REFRACTORY.
- Confirmation: conf increments (saturating) when exc_next≥A_LEVEL, and clears to 0 when exc_next<A_LEVEL.
- Refractory: refr decrements by 1 per sample while nonzero.
- Transitions, evaluated on exc_next and the updated conf:
  - C→A: conf reaches CONFIRM_A.
  - C→B: exc_next≥B_LEVEL and refr==0. The refr value used is the one before this edge's decrement.
  - B→A: conf reaches CONFIRM_A.
  - B→C: exc_next<B_LEVEL.
  - A→B: exc_next<A_LEVEL and exc_next≥B_LEVEL. refr loads REFRACTORY.
  - A→C: exc_next<B_LEVEL. refr loads REFRACTORY.
  - Otherwise the class holds.
- A→B is permitted during refractory. Only C→B is blocked.
- global_class: maximum class over enabled channels; 0 if no channel is enabled.

## Timing
- Reset values:
  - class_out=0, global_class=0, class_valid=0, class_change=0.
  - All internal state is 0.
- Latency:
  - class_out reflects the sample presented at the same edge, so it is visible the cycle after sample_valid.
  - global_class, class_valid and class_change are registered one further cycle. They are valid 2 cycles after sample_valid, coincident with each other.
- Back-to-back sample_valid on every cycle is supported at full rate.
- Reset asserted mid-operation clears everything at the next edge. A class_valid pulse already in flight is dropped.

## Test plan
- Single detection on ch0, defaults:
  - exc=100 and class_out[1:0]=1 after that edge.
  - global_class=1, class_valid=1 and class_change=1 two cycles after the strobe.
- Continuous detections on ch1:
  - exc reaches 500 on sample 5 and conf reaches 5 on sample 9, so class A appears on sample 9.
  - exc saturates at 1000 on sample 10 and stays there.
- Decay: exc=300 in class B, then no detections:
  - exc=200 at quiet sample 1000, 100 at 2000, 0 at 3000.
  - class→C at quiet sample 3000.
- Refractory: channel leaves A, then a single detection 500 samples later:
  - exc=100 but class stays C.
  - The same stimulus after REFRACTORY samples gives B.
- Timeout with DECAY_STEP=0: channel in A at exc=1000, then no detections:
  - class stays A through quiet sample 9999.
  - At quiet sample 10000: class=C, exc=0.
- Mask and reset:
  - With ch_enable=4'b0001 and detections on ch2: class_out[5:4] stays 0 and global_class stays 0.
  - Reset asserted while ch0 is in A: all outputs are 0 on the next cycle.
